// File: rtl/mtb_result_collector_if.sv
// Result-in / record-out handshake bundle for the miniTB result collector.
// master: test driver + log consumer; slave: the collector.
interface mtb_result_collector_if #(
  parameter int SUITE_W   = 2,
  parameter int TEST_ID_W = 8,
  parameter int CNT_W     = 16
);
  logic                 res_valid;
  logic                 res_ready;
  logic [SUITE_W-1:0]   res_suite;
  logic [TEST_ID_W-1:0] res_test;
  logic                 res_pass;
  logic                 log_valid;
  logic                 log_ready;
  logic [SUITE_W-1:0]   log_suite;
  logic [TEST_ID_W-1:0] log_test;
  logic                 log_pass;
  logic [CNT_W-1:0]     log_seq;

  modport master (
    output res_valid, res_suite, res_test, res_pass, log_ready,
    input  res_ready, log_valid, log_suite, log_test, log_pass, log_seq
  );

  modport slave (
    input  res_valid, res_suite, res_test, res_pass, log_ready,
    output res_ready, log_valid, log_suite, log_test, log_pass, log_seq
  );
endinterface

// File: rtl/mtb_result_collector.sv
// Collects miniTB pass/fail results, keeps totals/suite flags, buffers records.
// Ports: clk/rst/start/finish, bus (res_* in, log_* out), counters, state, verdict.
module mtb_result_collector #(
  parameter int NUM_SUITES = 4,
  parameter int TEST_ID_W  = 8,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  finish,
  mtb_result_collector_if.slave bus,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [NUM_SUITES-1:0] suite_fail,
  output logic                  bad_suite,
  output logic [1:0]            state,
  output logic                  done,
  output logic                  verdict
);
  localparam int SUITE_W =
    (NUM_SUITES > 1) ? $clog2(NUM_SUITES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int REC_W = SUITE_W + TEST_ID_W + 1 + CNT_W;
  localparam logic [AW:0]      P_ONE = (AW+1)'(1);
  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t cur, nxt;

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty;
  logic             push, pop, clr;
  logic [CNT_W:0]   total;
  logic [CNT_W-1:0] seq;
  logic [REC_W-1:0] head;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign bus.res_ready = (cur == S_RUN) && !full;
  assign bus.log_valid = !empty;
  assign push = bus.res_valid && bus.res_ready;
  assign pop  = bus.log_valid && bus.log_ready;
  assign clr  = start && (cur == S_IDLE || cur == S_DONE);

  // Stale storage is masked so log_* reads zero while empty.
  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign {bus.log_suite, bus.log_test,
          bus.log_pass, bus.log_seq} = head;

  assign total = {1'b0, pass_cnt} + {1'b0, fail_cnt};
  assign seq   = total[CNT_W] ? '1 : total[CNT_W-1:0];

  assign state   = cur;
  assign done    = (cur == S_DONE);
  assign verdict = done && (fail_cnt == '0) &&
                   (pass_cnt != '0) && !bad_suite;

  always_ff @(posedge clk) begin
    if (rst) cur <= S_IDLE;
    else     cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE:  if (start)  nxt = S_RUN;
      S_RUN:   if (finish) nxt = S_DRAIN;
      S_DRAIN: if (empty)  nxt = S_DONE;
      S_DONE:  if (start)  nxt = S_RUN;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= {bus.res_suite, bus.res_test,
                              bus.res_pass, seq};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      suite_fail <= '0;
      bad_suite  <= 1'b0;
    end else if (push) begin
      if (bus.res_pass) begin
        if (pass_cnt != '1) pass_cnt <= pass_cnt + C_ONE;
      end else begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + C_ONE;
        for (int i = 0; i < NUM_SUITES; i++)
          if (int'(bus.res_suite) == i) suite_fail[i] <= 1'b1;
      end
      if (int'(bus.res_suite) >= NUM_SUITES) bad_suite <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mtb_result_collector.sv
// Directed bench for mtb_result_collector: vector table plus corner sequences.
// Two instances: default NUM_SUITES=4 and NUM_SUITES=3 for the bad-suite case.
module tb_mtb_result_collector;
  logic clk = 1'b0;
  logic rst, start, finish, start3, finish3;
  always #5 clk = ~clk;

  mtb_result_collector_if #(.SUITE_W(2)) bus ();
  mtb_result_collector_if #(.SUITE_W(2)) bus3 ();

  logic [15:0] pass_cnt, fail_cnt, pass_cnt3, fail_cnt3;
  logic [3:0]  suite_fail;
  logic [2:0]  suite_fail3;
  logic        bad_suite, done, verdict;
  logic        bad_suite3, done3, verdict3;
  logic [1:0]  state, state3;

  mtb_result_collector u_dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .bus(bus.slave),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
    .suite_fail(suite_fail), .bad_suite(bad_suite),
    .state(state), .done(done), .verdict(verdict)
  );

  mtb_result_collector #(.NUM_SUITES(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .finish(finish3),
    .bus(bus3.slave),
    .pass_cnt(pass_cnt3), .fail_cnt(fail_cnt3),
    .suite_fail(suite_fail3), .bad_suite(bad_suite3),
    .state(state3), .done(done3), .verdict(verdict3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int st, fin, v, su, te, pa, lr;
    int e_state, e_pass, e_fail, e_lv, e_seq, e_test, e_sf;
    int e_done, e_verdict;
  } vec_t;

  vec_t tbl [12];
  int acc, got;

  initial begin
    tbl[0]  = '{1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0};
    tbl[1]  = '{0,0,1,0,1,1,1, 1,1,0,1,0,1,0,0,0};
    tbl[2]  = '{0,0,1,2,7,0,1, 1,1,1,1,1,7,4,0,0};
    tbl[3]  = '{0,0,1,1,3,1,1, 1,2,1,1,2,3,4,0,0};
    tbl[4]  = '{0,1,0,0,0,0,1, 2,2,1,0,0,0,4,0,0};
    tbl[5]  = '{0,0,0,0,0,0,1, 3,2,1,0,0,0,4,1,0};
    tbl[6]  = '{1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0,0};
    tbl[7]  = '{0,0,1,3,9,1,0, 1,1,0,1,0,9,0,0,0};
    tbl[8]  = '{0,1,1,1,4,1,0, 2,2,0,1,0,9,0,0,0};
    tbl[9]  = '{0,0,0,0,0,0,1, 2,2,0,1,1,4,0,0,0};
    tbl[10] = '{0,0,0,0,0,0,1, 2,2,0,0,0,0,0,0,0};
    tbl[11] = '{0,0,0,0,0,0,0, 3,2,0,0,0,0,0,1,1};

    rst = 1'b1; start = 1'b0; finish = 1'b0;
    start3 = 1'b0; finish3 = 1'b0;
    bus.res_valid = 1'b0; bus.res_suite = '0;
    bus.res_test = '0; bus.res_pass = 1'b0; bus.log_ready = 1'b0;
    bus3.res_valid = 1'b0; bus3.res_suite = '0;
    bus3.res_test = '0; bus3.res_pass = 1'b0; bus3.log_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_state", 32'(state), 0);
    chk("rst_log_valid", 32'(bus.log_valid), 0);
    chk("rst_res_ready", 32'(bus.res_ready), 0);
    chk("rst_pass", 32'(pass_cnt), 0);
    chk("rst_fail", 32'(fail_cnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_verdict", 32'(verdict), 0);
    chk("rst_log_seq", 32'(bus.log_seq), 0);

    // finish ignored in IDLE
    finish = 1'b1;
    tick();
    finish = 1'b0;
    chk("idle_finish", 32'(state), 0);

    for (int i = 0; i < 12; i++) begin
      start         = tbl[i].st[0];
      finish        = tbl[i].fin[0];
      bus.res_valid = tbl[i].v[0];
      bus.res_suite = 2'(tbl[i].su);
      bus.res_test  = 8'(tbl[i].te);
      bus.res_pass  = tbl[i].pa[0];
      bus.log_ready = tbl[i].lr[0];
      tick();
      chk($sformatf("v%0d_state", i), 32'(state), tbl[i].e_state);
      chk($sformatf("v%0d_pass", i), 32'(pass_cnt), tbl[i].e_pass);
      chk($sformatf("v%0d_fail", i), 32'(fail_cnt), tbl[i].e_fail);
      chk($sformatf("v%0d_lv", i), 32'(bus.log_valid), tbl[i].e_lv);
      chk($sformatf("v%0d_seq", i), 32'(bus.log_seq), tbl[i].e_seq);
      chk($sformatf("v%0d_test", i), 32'(bus.log_test), tbl[i].e_test);
      chk($sformatf("v%0d_sf", i), 32'(suite_fail), tbl[i].e_sf);
      chk($sformatf("v%0d_done", i), 32'(done), tbl[i].e_done);
      chk($sformatf("v%0d_verdict", i), 32'(verdict), tbl[i].e_verdict);
    end
    start = 1'b0; finish = 1'b0;
    bus.res_valid = 1'b0; bus.log_ready = 1'b0;

    // backpressure: 10 offered, FIFO holds 8
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bp_state", 32'(state), 1);
    acc = 0;
    got = 0;
    bus.res_valid = 1'b1; bus.res_pass = 1'b1;
    bus.res_suite = 2'd0; bus.res_test = 8'd0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) acc++;
      tick();
      bus.res_test = 8'(acc);
      if (acc == 10) bus.res_valid = 1'b0;
    end
    chk("bp_accepted", 32'(acc), 8);
    @(negedge clk);
    chk("bp_ready_low", 32'(bus.res_ready), 0);
    tick();
    bus.log_ready = 1'b1;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      if (bus.res_valid && bus.res_ready) acc++;
      if (bus.log_valid) begin
        chk("bp_seq", 32'(bus.log_seq), 32'(got));
        chk("bp_test", 32'(bus.log_test), 32'(got));
        got++;
      end
      tick();
      bus.res_test = 8'(acc);
      if (acc == 10) bus.res_valid = 1'b0;
    end
    chk("bp_logged", 32'(got), 10);
    chk("bp_acc_total", 32'(acc), 10);
    bus.res_valid = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int c = 0; c < 20 && !done; c++) tick();
    chk("bp_done", 32'(done), 1);
    chk("bp_pass", 32'(pass_cnt), 10);
    chk("bp_verdict", 32'(verdict), 1);

    // DRAIN holds while records are buffered
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.log_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.res_valid = 1'b1; bus.res_pass = 1'b1;
      bus.res_test = 8'(20 + k);
      tick();
    end
    bus.res_valid = 1'b0;
    finish = 1'b1;
    tick();
    finish = 1'b0;
    repeat (5) tick();
    chk("dr_hold_state", 32'(state), 2);
    chk("dr_hold_lv", 32'(bus.log_valid), 1);
    chk("dr_head_seq", 32'(bus.log_seq), 0);
    chk("dr_head_test", 32'(bus.log_test), 20);
    bus.log_ready = 1'b1;
    repeat (3) tick();
    bus.log_ready = 1'b0;
    chk("dr_empty_state", 32'(state), 2);
    chk("dr_empty_lv", 32'(bus.log_valid), 0);
    tick();
    chk("dr_done_state", 32'(state), 3);
    chk("dr_verdict", 32'(verdict), 1);
    chk("dr_pass", 32'(pass_cnt), 3);

    // out-of-range suite on the 3-suite instance
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    bus3.log_ready = 1'b1;
    bus3.res_valid = 1'b1; bus3.res_suite = 2'd3;
    bus3.res_test = 8'd5; bus3.res_pass = 1'b1;
    tick();
    bus3.res_valid = 1'b0;
    chk("bs_flag_run", 32'(bad_suite3), 1);
    finish3 = 1'b1;
    tick();
    finish3 = 1'b0;
    for (int c = 0; c < 20 && !done3; c++) tick();
    chk("bs_done", 32'(done3), 1);
    chk("bs_pass", 32'(pass_cnt3), 1);
    chk("bs_verdict", 32'(verdict3), 0);
    chk("bs_suite_fail", 32'(suite_fail3), 0);

    // reset mid-run with 5 buffered
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.log_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.res_valid = 1'b1; bus.res_pass = 1'b1;
      bus.res_test = 8'(30 + k);
      tick();
    end
    bus.res_valid = 1'b0;
    chk("mr_state", 32'(state), 1);
    chk("mr_pass", 32'(pass_cnt), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_rst_state", 32'(state), 0);
    chk("mr_rst_lv", 32'(bus.log_valid), 0);
    chk("mr_rst_pass", 32'(pass_cnt), 0);
    chk("mr_rst_ready", 32'(bus.res_ready), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    bus.res_valid = 1'b1; bus.res_pass = 1'b0;
    bus.res_suite = 2'd1; bus.res_test = 8'd40;
    tick();
    bus.res_valid = 1'b0;
    chk("mr_seq0", 32'(bus.log_seq), 0);
    chk("mr_test", 32'(bus.log_test), 40);
    chk("mr_fail", 32'(fail_cnt), 1);
    chk("mr_sf", 32'(suite_fail), 2);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
